uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, falling-edge start detection,
// mid-bit sampling, one-cycle data_valid / frame_err pulses.
module uart_rx #(
  parameter int Fclk  = 100000000,
  parameter int Fuart = 9600
) (
  input  logic       clk_Rx,
  input  logic       reset,
  input  logic       Rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = Fclk / Fuart;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [24:0] CNT_BIT_END  = 25'(CLKS_PER_BIT - 1);
  localparam logic [24:0] CNT_HALF_END = 25'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic        rx_prev;
  logic [24:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  // rx_prev tracks rx_s every cycle so a held-low line never looks like a new edge
  always_ff @(posedge clk_Rx or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= Rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_Rx or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (rx_prev && !rx_s) begin
            state <= START_BIT;
            busy  <= 1'b1;
          end
        end
        START_BIT: begin
          if (clk_cnt == CNT_HALF_END) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state <= DATA_BIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 25'd1;
          end
        end
        DATA_BIT: begin
          if (clk_cnt == CNT_BIT_END) begin
            clk_cnt            <= '0;
            shift_reg[bit_cnt] <= rx_s;
            if (bit_cnt == 3'd7) begin
              state <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 25'd1;
          end
        end
        STOP_BIT: begin
          // Leave at mid stop bit so the next start edge is caught in IDLE
          if (clk_cnt == CNT_BIT_END) begin
            clk_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 25'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit (10 ns clock, 100 ns bit).
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk_Rx;
  logic       reset;
  logic       Rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  int       cyc = 0;
  int       n_valid = 0;
  int       n_err = 0;
  int       last_valid_cyc = 0;
  bit       both_hi = 1'b0;
  logic [7:0] rx_log [$];

  int start_cyc;
  int v0, e0, lat;
  bit seen;

  uart_rx #(.Fclk(1000000), .Fuart(100000)) dut (
    .clk_Rx    (clk_Rx),
    .reset     (reset),
    .Rx_in     (Rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk_Rx = 1'b0;
  always #5 clk_Rx = ~clk_Rx;

  always @(posedge clk_Rx) cyc <= cyc + 1;

  always @(negedge clk_Rx) begin
    if (data_valid) begin
      n_valid        <= n_valid + 1;
      last_valid_cyc <= cyc;
      rx_log.push_back(data_out);
    end
    if (frame_err) n_err <= n_err + 1;
    if (data_valid && frame_err) both_hi <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
    Rx_in = 1'b0;
    start_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      Rx_in = b[i];
      #(bit_ns);
    end
    Rx_in = stop;
    #(bit_ns);
  endtask

  task automatic align();
    @(negedge clk_Rx);
    #2;
  endtask

  logic [7:0] baud_byte [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
  int         baud_ns   [4] = '{98, 102, 102, 98};

  initial begin
    Rx_in = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk_Rx);
    chk("rst_data_out", {24'h0, data_out}, 32'h00);
    chk("rst_valid", {31'h0, data_valid}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk_Rx);

    // single byte 'r'
    v0 = n_valid; e0 = n_err;
    align();
    send_frame(8'h72, 1'b1, 100);
    repeat (20) @(negedge clk_Rx);
    chk("r_valid_cnt", n_valid - v0, 1);
    chk("r_ferr_cnt", n_err - e0, 0);
    chk("r_data", {24'h0, data_out}, 32'h72);
    lat = last_valid_cyc - start_cyc;
    chk("r_latency_in_92_101", {31'h0, (lat >= 92 && lat <= 101)}, 1);

    // back-to-back frames
    v0 = n_valid;
    align();
    send_frame(8'h55, 1'b1, 100);
    send_frame(8'hA3, 1'b1, 100);
    repeat (20) @(negedge clk_Rx);
    chk("b2b_valid_cnt", n_valid - v0, 2);
    if (rx_log.size() >= 2) begin
      chk("b2b_first", {24'h0, rx_log[rx_log.size()-2]}, 32'h55);
      chk("b2b_second", {24'h0, rx_log[rx_log.size()-1]}, 32'hA3);
    end else begin
      chk("b2b_log_size", rx_log.size(), 2);
    end

    // framing error followed by break
    v0 = n_valid; e0 = n_err;
    align();
    send_frame(8'hFF, 1'b0, 100);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk_Rx);
      if (busy) seen = 1'b1;
    end
    chk("brk_ferr_cnt", n_err - e0, 1);
    chk("brk_valid_cnt", n_valid - v0, 0);
    chk("brk_data_kept", {24'h0, data_out}, 32'hA3);
    chk("brk_busy_low", {31'h0, seen}, 0);
    Rx_in = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_Rx);
      if (busy) seen = 1'b1;
    end
    chk("brk_rise_busy_low", {31'h0, seen}, 0);

    // 3-clock glitch on idle line
    v0 = n_valid; e0 = n_err;
    seen = 1'b0;
    align();
    Rx_in = 1'b0;
    repeat (3) begin
      @(negedge clk_Rx);
      if (busy) seen = 1'b1;
    end
    #2 Rx_in = 1'b1;
    repeat (7) begin
      @(negedge clk_Rx);
      if (busy) seen = 1'b1;
    end
    chk("glitch_busy_seen", {31'h0, seen}, 1);
    chk("glitch_busy_back", {31'h0, busy}, 0);
    repeat (20) @(negedge clk_Rx);
    chk("glitch_valid_cnt", n_valid - v0, 0);
    chk("glitch_ferr_cnt", n_err - e0, 0);

    // reset during data bit 4 of 0x0F, held until the frame is over
    v0 = n_valid; e0 = n_err;
    align();
    fork
      send_frame(8'h0F, 1'b1, 100);
      begin
        #550;
        reset = 1'b0;
        @(negedge clk_Rx);
        chk("mid_rst_data_out", {24'h0, data_out}, 32'h00);
        chk("mid_rst_valid", {31'h0, data_valid}, 0);
        chk("mid_rst_ferr", {31'h0, frame_err}, 0);
        chk("mid_rst_busy", {31'h0, busy}, 0);
      end
    join
    #100;
    reset = 1'b1;
    repeat (20) @(negedge clk_Rx);
    chk("mid_rst_no_pulse", n_valid - v0, 0);
    align();
    send_frame(8'hC3, 1'b1, 100);
    repeat (20) @(negedge clk_Rx);
    chk("after_rst_valid_cnt", n_valid - v0, 1);
    chk("after_rst_data", {24'h0, data_out}, 32'hC3);
    chk("after_rst_ferr_cnt", n_err - e0, 0);

    // +-2% baud tolerance
    for (int k = 0; k < 4; k++) begin
      v0 = n_valid; e0 = n_err;
      align();
      send_frame(baud_byte[k], 1'b1, baud_ns[k]);
      repeat (30) @(negedge clk_Rx);
      chk($sformatf("baud%0d_valid_cnt", k), n_valid - v0, 1);
      chk($sformatf("baud%0d_data", k), {24'h0, data_out}, {24'h0, baud_byte[k]});
      chk($sformatf("baud%0d_ferr_cnt", k), n_err - e0, 0);
    end

    chk("never_both_pulses", {31'h0, both_hi}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
